// File: rtl/zone_select_ctrl_if.sv
// zone_select_ctrl_if
// Groups the button, frame-timing and pixel-zone inputs of the zone selector
// together with its cursor/state/highlight outputs.
//   master : drives buttons, frame_start, pixel_zone; observes outputs
//   slave  : the zone_select_ctrl side
interface zone_select_ctrl_if;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_select;
    logic       btn_cancel;
    logic       frame_start;
    logic [1:0] pixel_zone;
    logic [1:0] cursor;
    logic [1:0] state_o;
    logic       zone_valid;
    logic       locked;
    logic       highlight;

    modport master (
        output btn_next, btn_prev, btn_select, btn_cancel, frame_start, pixel_zone,
        input  cursor, state_o, zone_valid, locked, highlight
    );

    modport slave (
        input  btn_next, btn_prev, btn_select, btn_cancel, frame_start, pixel_zone,
        output cursor, state_o, zone_valid, locked, highlight
    );
endinterface

// File: rtl/zone_select_ctrl.sv
// zone_select_ctrl
// Four-quadrant selector for the VGA screen: moves a cursor over zones 0..3 on
// next/prev button edges, confirms a choice after a frame-timed hold and locks
// it, and produces the registered per-pixel highlight for the pixel mixer.
// Ports:
//   clk   : pixel clock
//   reset : synchronous, active-high
//   bus   : zone_select_ctrl_if.slave (buttons, frame_start, pixel_zone in;
//           cursor, state_o, zone_valid, locked, highlight out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// BROWSE  | cursor moves freely, highlight blinks every BLINK_FRAMES
// CONFIRM | choice held, waiting CONFIRM_FRAMES frames (cancel aborts)
// LOCK    | choice locked, zone_valid pulsed on entry (cancel unlocks)
module zone_select_ctrl #(
    parameter int unsigned BLINK_FRAMES   = 30,
    parameter int unsigned CONFIRM_FRAMES = 60
) (
    input logic               clk,
    input logic               reset,
    zone_select_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        BROWSE  = 2'b00,
        CONFIRM = 2'b01,
        LOCK    = 2'b10
    } state_t;

    localparam logic [7:0] BLINK_LAST   = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] CONFIRM_LAST = 8'(CONFIRM_FRAMES - 1);

    // bit order: {cancel, select, prev, next}
    logic [3:0] btn_raw;
    logic [3:0] s1_q, s2_q, prev_q;
    logic [3:0] btn_edge;

    state_t     state_q, state_d;
    logic [1:0] cursor_q, cursor_d;
    logic [7:0] cnt_q, cnt_d;
    logic       blink_q, blink_d;
    logic       zone_valid_q, zone_valid_d;
    logic       locked_q, locked_d;
    logic       highlight_q, highlight_d;

    logic nxt_e, prv_e, sel_e, can_e;

    assign btn_raw  = {bus.btn_cancel, bus.btn_select, bus.btn_prev, bus.btn_next};
    assign btn_edge = s2_q & ~prev_q;
    assign nxt_e    = btn_edge[0];
    assign prv_e    = btn_edge[1];
    assign sel_e    = btn_edge[2];
    assign can_e    = btn_edge[3];

    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        cnt_d        = cnt_q;
        blink_d      = blink_q;
        zone_valid_d = 1'b0;

        case (state_q)
            BROWSE: begin
                if (sel_e) begin
                    state_d = CONFIRM;
                    cnt_d   = 8'd0;
                end else if (nxt_e != prv_e) begin
                    // a move restarts the blink with the highlight visible
                    cursor_d = nxt_e ? cursor_q + 2'd1 : cursor_q - 2'd1;
                    blink_d  = 1'b1;
                    cnt_d    = 8'd0;
                end else if (bus.frame_start) begin
                    if (cnt_q == BLINK_LAST) begin
                        blink_d = ~blink_q;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            CONFIRM: begin
                if (can_e) begin
                    state_d = BROWSE;
                    cnt_d   = 8'd0;
                    blink_d = 1'b1;
                end else if (bus.frame_start) begin
                    if (cnt_q == CONFIRM_LAST) begin
                        state_d      = LOCK;
                        cnt_d        = 8'd0;
                        zone_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            LOCK: begin
                if (can_e) begin
                    state_d = BROWSE;
                    cnt_d   = 8'd0;
                    blink_d = 1'b1;
                end
            end
            default: begin
                state_d = BROWSE;
                cnt_d   = 8'd0;
                blink_d = 1'b1;
            end
        endcase

        locked_d    = (state_d == LOCK);
        highlight_d = (bus.pixel_zone == cursor_q) && ((state_q != BROWSE) || blink_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // flops preset high so a button held through reset never fires
            s1_q         <= 4'hF;
            s2_q         <= 4'hF;
            prev_q       <= 4'hF;
            state_q      <= BROWSE;
            cursor_q     <= 2'd0;
            cnt_q        <= 8'd0;
            blink_q      <= 1'b1;
            zone_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            highlight_q  <= 1'b0;
        end else begin
            s1_q         <= btn_raw;
            s2_q         <= s1_q;
            prev_q       <= s2_q;
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            cnt_q        <= cnt_d;
            blink_q      <= blink_d;
            zone_valid_q <= zone_valid_d;
            locked_q     <= locked_d;
            highlight_q  <= highlight_d;
        end
    end

    assign bus.cursor     = cursor_q;
    assign bus.state_o    = state_q;
    assign bus.zone_valid = zone_valid_q;
    assign bus.locked     = locked_q;
    assign bus.highlight  = highlight_q;

endmodule

// File: tb/tb_zone_select_ctrl.sv
module tb_zone_select_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    zone_select_ctrl_if bus ();

    zone_select_ctrl #(
        .BLINK_FRAMES  (2),
        .CONFIRM_FRAMES(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // button masks: {cancel, select, prev, next}
    localparam logic [3:0] B_N = 4'b0001;
    localparam logic [3:0] B_P = 4'b0010;
    localparam logic [3:0] B_S = 4'b0100;
    localparam logic [3:0] B_C = 4'b1000;
    localparam logic [3:0] B_0 = 4'b0000;

    typedef struct {
        logic [3:0] btn;
        int         frames;
        logic [1:0] pz;
        logic [1:0] cur;
        logic [1:0] st;
        logic       lk;
        logic       hl;
    } vec_t;

    vec_t tbl_a [13];
    vec_t tbl_b [10];
    vec_t sb_q [$];

    int n_chk  = 0;
    int n_fail = 0;
    int zv_count = 0;

    always @(negedge clk) if (bus.zone_valid === 1'b1) zv_count++;

    function automatic vec_t mk(logic [3:0] btn, int frames, logic [1:0] pz,
                                logic [1:0] cur, logic [1:0] st, logic lk, logic hl);
        vec_t v;
        v.btn = btn; v.frames = frames; v.pz = pz;
        v.cur = cur; v.st = st; v.lk = lk; v.hl = hl;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        bus.btn_next   = b[0];
        bus.btn_prev   = b[1];
        bus.btn_select = b[2];
        bus.btn_cancel = b[3];
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        vec_t e;
        sb_q.push_back(v);
        bus.pixel_zone = v.pz;
        if (v.btn != B_0) begin
            set_btn(v.btn);
            repeat (3) tick();
            set_btn(B_0);
            repeat (3) tick();
        end
        for (int f = 0; f < v.frames; f++) begin
            bus.frame_start = 1'b1;
            tick();
            bus.frame_start = 1'b0;
            tick();
        end
        tick();
        e = sb_q.pop_front();
        chk($sformatf("%s[%0d].cursor", tag, idx), int'(bus.cursor), int'(e.cur));
        chk($sformatf("%s[%0d].state", tag, idx), int'(bus.state_o), int'(e.st));
        chk($sformatf("%s[%0d].locked", tag, idx), int'(bus.locked), int'(e.lk));
        chk($sformatf("%s[%0d].highlight", tag, idx), int'(bus.highlight), int'(e.hl));
    endtask

    initial begin
        //                btn        fr pz  cur st lk hl
        tbl_a[0]  = mk(B_P,       0, 0, 0, 0, 0, 1);  // 1 -> 0
        tbl_a[1]  = mk(B_P,       0, 3, 3, 0, 0, 1);  // 0 -> 3 wrap
        tbl_a[2]  = mk(B_N,       0, 1, 0, 0, 0, 0);  // 3 -> 0 wrap
        tbl_a[3]  = mk(B_N,       0, 1, 1, 0, 0, 1);
        tbl_a[4]  = mk(B_N | B_P, 0, 1, 1, 0, 0, 1);  // simultaneous: no move
        tbl_a[5]  = mk(B_0,       1, 1, 1, 0, 0, 1);  // blink 1,0,0,1,1,0
        tbl_a[6]  = mk(B_0,       1, 1, 1, 0, 0, 0);
        tbl_a[7]  = mk(B_0,       1, 1, 1, 0, 0, 0);
        tbl_a[8]  = mk(B_0,       1, 1, 1, 0, 0, 1);
        tbl_a[9]  = mk(B_0,       1, 1, 1, 0, 0, 1);
        tbl_a[10] = mk(B_0,       1, 1, 1, 0, 0, 0);
        tbl_a[11] = mk(B_N,       0, 2, 2, 0, 0, 1);  // move mid-blink restores
        tbl_a[12] = mk(B_0,       0, 0, 2, 0, 0, 0);  // other zone

        tbl_b[0]  = mk(B_N,       2, 2, 2, 2, 1, 1);  // LOCK ignores next
        tbl_b[1]  = mk(B_S,       0, 2, 2, 2, 1, 1);  // LOCK ignores select
        tbl_b[2]  = mk(B_C,       0, 2, 2, 0, 0, 1);  // cancel keeps cursor
        tbl_b[3]  = mk(B_C,       0, 2, 2, 0, 0, 1);  // BROWSE ignores cancel
        tbl_b[4]  = mk(B_S | B_N, 0, 2, 2, 1, 0, 1);  // select wins over next
        tbl_b[5]  = mk(B_0,       1, 2, 2, 1, 0, 1);
        tbl_b[6]  = mk(B_C,       0, 2, 2, 0, 0, 1);  // cancel after 1 frame
        tbl_b[7]  = mk(B_S,       0, 2, 2, 1, 0, 1);
        tbl_b[8]  = mk(B_N,       1, 2, 2, 1, 0, 1);  // CONFIRM ignores next
        tbl_b[9]  = mk(B_0,       1, 2, 2, 1, 0, 1);  // 2 of 3 frames

        // reset with next held; it must not fire until released
        reset = 1'b1;
        set_btn(B_N);
        bus.frame_start = 1'b0;
        bus.pixel_zone  = 2'd2;
        repeat (3) tick();
        chk("rst.cursor", int'(bus.cursor), 0);
        chk("rst.state", int'(bus.state_o), 0);
        chk("rst.zone_valid", int'(bus.zone_valid), 0);
        chk("rst.locked", int'(bus.locked), 0);
        chk("rst.highlight", int'(bus.highlight), 0);
        reset = 1'b0;
        repeat (10) begin
            tick();
            chk("held_next.cursor", int'(bus.cursor), 0);
        end
        set_btn(B_0);
        repeat (3) tick();
        set_btn(B_N);
        tick();
        tick();
        chk("next_latency_e1.cursor", int'(bus.cursor), 0);
        tick();
        chk("next_latency_e2.cursor", int'(bus.cursor), 1);
        set_btn(B_0);
        repeat (3) tick();

        for (int i = 0; i < 13; i++) apply(tbl_a[i], "browse", i);

        // select with a coincident frame_start (not counted), then 3 frames
        bus.pixel_zone = 2'd2;
        set_btn(B_S);
        tick();
        tick();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("sel.state", int'(bus.state_o), 1);
        set_btn(B_0);
        repeat (3) tick();
        for (int k = 1; k <= 3; k++) begin
            bus.frame_start = 1'b1;
            tick();
            bus.frame_start = 1'b0;
            if (k < 3) begin
                chk($sformatf("confirm_f%0d.state", k), int'(bus.state_o), 1);
                chk($sformatf("confirm_f%0d.zone_valid", k), int'(bus.zone_valid), 0);
            end else begin
                chk("lock_entry.state", int'(bus.state_o), 2);
                chk("lock_entry.zone_valid", int'(bus.zone_valid), 1);
                chk("lock_entry.locked", int'(bus.locked), 1);
            end
            tick();
            if (k == 3) begin
                chk("lock_next.zone_valid", int'(bus.zone_valid), 0);
                chk("lock_next.locked", int'(bus.locked), 1);
            end
            tick();
        end
        chk("lock.highlight", int'(bus.highlight), 1);
        chk("lock.zv_count", zv_count, 1);

        for (int i = 0; i < 10; i++) apply(tbl_b[i], "lockcfm", i);

        // reset after 2 of the 3 confirm frames: back to BROWSE, no pulse
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_cfm.state", int'(bus.state_o), 0);
        chk("rst_cfm.cursor", int'(bus.cursor), 0);
        chk("rst_cfm.locked", int'(bus.locked), 0);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        repeat (2) tick();
        chk("rst_cfm_after.state", int'(bus.state_o), 0);
        chk("rst_cfm_after.highlight", int'(bus.highlight), 0);
        chk("final.zv_count", zv_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/zone_select_ctrl.md
# zone_select_ctrl

Sequential controller for the four-quadrant screen selector of the VGA application. It keeps a cursor over zones 0–3, moves it on next/prev button edges, and confirms a choice with a frame-timed hold before locking it. It generates the per-pixel highlight that the pixel mixer uses to outline the selected quadrant. It sits between the debounced board buttons, the VGA timing generator (frame_start) and the combinational zone decoder (pixel_zone).

## Interface

- BLINK_FRAMES, 30, frames per blink half-period in BROWSE; legal 1..255
- CONFIRM_FRAMES, 60, frames held in CONFIRM before LOCK; legal 1..255
- clk  in  1  pixel clock
- reset  in  1  reset, synchronous, active-high
- btn_next  in  1  debounced level, asynchronous to clk
- btn_prev  in  1  debounced level, asynchronous to clk
- btn_select  in  1  debounced level, asynchronous to clk
- btn_cancel  in  1  debounced level, asynchronous to clk
- frame_start  in  1  one-cycle pulse per frame from VGA timing
- pixel_zone  in  2  zone of the current pixel, from the zone decoder
- cursor  out  2  currently pointed zone
- state_o  out  2  FSM state: 00 BROWSE, 01 CONFIRM, 10 LOCK
- zone_valid  out  1  one-cycle pulse on entry to LOCK
- locked  out  1  high while in LOCK
- highlight  out  1  registered; current pixel lies in the highlighted zone

## Operation

- Each button passes through a 2-flop synchronizer, then a rising-edge detector (edge = s2 & ~prev). All three flops reset to 1, so a button held through reset never fires; it must be released first.
- FSM states:
  - BROWSE: next edge → cursor+1 mod 4 (3→0); prev edge → cursor−1 mod 4 (0→3).
  - BROWSE, simultaneous next and prev edges: cursor unchanged.
  - BROWSE, select edge → CONFIRM; select has priority over next/prev in the same cycle, and cursor is unchanged. Cancel is ignored.
  - CONFIRM: next/prev/select ignored. Cancel edge → BROWSE. On the frame_start that completes CONFIRM_FRAMES frames → LOCK.
  - LOCK: next/prev/select ignored. Cancel edge → BROWSE, with cursor kept.
- Frame counter is 8 bits, cleared on every state change.
- Blink, BROWSE only:
  - Each frame_start increments frame_cnt.
  - When frame_cnt == BLINK_FRAMES−1 on a frame_start, blink_phase toggles and frame_cnt clears.
  - Any cursor move forces blink_phase=1 and frame_cnt=0.
  - Entering BROWSE sets blink_phase=1.
- CONFIRM exit: when frame_cnt == CONFIRM_FRAMES−1 on a frame_start, the FSM moves to LOCK and zone_valid pulses.
- Highlight enable: (pixel_zone == cursor) & (state != BROWSE | blink_phase).
- Priority within a cycle: reset > cancel > select > next/prev > frame_start.
- Reset mid-CONFIRM: returns to BROWSE with no zone_valid pulse.

## Timing

- Reset values: cursor=0, state_o=00, zone_valid=0, locked=0, highlight=0, blink_phase=1, frame_cnt=0.
- Button latency: input high before edge 0 → s1 set at edge 0, s2 at edge 1 → cursor/state change at edge 2.
- Button minimum high/low time: 3 cycles.
- highlight is pixel_zone/cursor/state registered once: 1-cycle latency from pixel_zone.
- zone_valid and locked rise on the same clock edge as the CONFIRM→LOCK transition. zone_valid falls the next cycle; locked stays high until LOCK exits.
- CONFIRM duration is exactly CONFIRM_FRAMES frame_start pulses counted after entry. A frame_start in the same cycle as the select edge is not counted.
- frame_start in the same cycle as a cursor move: the move wins, so the count clears.

## Test plan

Bench parameters: BLINK_FRAMES=2, CONFIRM_FRAMES=3.

- Reset with btn_next held high, release reset, keep btn_next high 10 cycles → cursor stays 0. Then release and re-press → cursor=1 three edges after the press.
- From cursor=0: prev → 3; next, next → 1; next and prev pressed on the same cycle → cursor unchanged at 1.
- BROWSE, pixel_zone=cursor, 4 frame_start pulses → highlight 1,1,0,0,1 pattern, toggling every 2 frames.
- Cursor move mid-blink → highlight returns to 1 on the next pixel cycle.
- select, then 3 frame_start pulses → state_o 01, then 10 on the third pulse. zone_valid is high for exactly 1 cycle, locked stays 1, highlight is solid.
- In LOCK, next edge → cursor unchanged. Cancel edge → state_o=00, locked=0, cursor retained.
- Assert reset after 2 of the 3 CONFIRM frames → state_o=00, cursor=0, zone_valid never pulses.
- Cancel after 1 CONFIRM frame → BROWSE.
- select and next on the same cycle → CONFIRM with cursor unchanged.
